// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scan decoder: FSM states, mode encodings
// and the polarity-aware one-hot pattern generator.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_N     = 1 << MAX_SEL_W;

    // Result is MAX_N wide; callers size-cast it down to their own line count.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx,
                                                 input int unsigned n,
                                                 input logic        active_low);
        logic [MAX_N-1:0] p;
        logic [MAX_N-1:0] mask;
        p = '0;
        p[idx[MAX_SEL_W-1:0]] = 1'b1;
        mask = (MAX_N'(1) << n) - MAX_N'(1);
        return active_low ? (~p & mask) : p;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler for scan mode: counts 0..div_load while running, holds
// its value while frozen, and pulses tick on the terminal count.
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] div_load,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a lowered div_load terminates the dwell at once.
    assign tick = run && (cnt >= div_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered 2^SEL_W-line decoder with 74x138-style enables and an
// auto-scan mode that walks the outputs with a programmable dwell.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    g1,
    input  logic                    g2an,
    input  logic                    g2bn,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DIV_W-1:0]        div_load,
    output logic [(1<<SEL_W)-1:0]   y_n,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    wrap
);

    localparam int unsigned N        = 1 << SEL_W;
    localparam logic [N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

    state_t           state;
    state_t           nxt;
    logic             en;
    logic             last_direct;
    logic             restart;
    logic             run;
    logic             clear;
    logic             tick;
    logic             wrap_nxt;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] idx_nxt;
    logic [N-1:0]     y_nxt;

    // Counting happens only on SCAN->SCAN edges; the entry edge loads or resumes.
    always_comb begin
        en      = g1 & ~g2an & ~g2bn;
        nxt     = IDLE;
        if (en) begin
            nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
        restart = (nxt == SCAN) &&
                  ((state == DIRECT) || ((state == IDLE) && last_direct));
        run     = (state == SCAN) && (nxt == SCAN);
        clear   = (nxt == DIRECT) || restart;
    end

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .clear    (clear),
        .div_load (div_load),
        .tick     (tick)
    );

    always_comb begin
        idx_nxt  = idx;
        wrap_nxt = 1'b0;
        case (nxt)
            DIRECT: idx_nxt = sel;
            SCAN: begin
                if (restart) begin
                    idx_nxt = '0;
                end else if (tick) begin
                    idx_nxt  = idx + SEL_W'(1);
                    wrap_nxt = (idx == '1);
                end
            end
            default: ;
        endcase
        y_nxt = (nxt == IDLE) ? INACTIVE
                              : N'(onehot(32'(idx_nxt), N, ACTIVE_LOW != 0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_direct <= 1'b0;
            idx         <= '0;
            y_n         <= INACTIVE;
            wrap        <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != IDLE) begin
                last_direct <= (nxt == DIRECT);
            end
            idx  <= idx_nxt;
            y_n  <= y_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign cur_sel = idx;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed scenarios plus a randomized
// run against a frame-arithmetic reference model.
module tb_scan_decoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, g1, g2an, g2bn, mode;
    logic [2:0]  sel;
    logic [15:0] div_load;
    logic [7:0]  y_n;
    logic [2:0]  cur_sel;
    logic        wrap;

    logic        rst2_n, g1b, g2anb, g2bnb, mode2;
    logic [3:0]  sel2;
    logic [7:0]  div2;
    logic [15:0] y2;
    logic [3:0]  cur2;
    logic        wrap2;

    int n_cmp = 0;
    int n_bad = 0;

    scan_decoder #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .g1(g1), .g2an(g2an), .g2bn(g2bn),
        .mode(mode), .sel(sel), .div_load(div_load),
        .y_n(y_n), .cur_sel(cur_sel), .wrap(wrap)
    );

    scan_decoder #(.SEL_W(4), .DIV_W(8), .ACTIVE_LOW(0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .g1(g1b), .g2an(g2anb), .g2bn(g2bnb),
        .mode(mode2), .sel(sel2), .div_load(div2),
        .y_n(y2), .cur_sel(cur2), .wrap(wrap2)
    );

    // Reference model: scan position is the number of counting edges since
    // the last restart; index and wrap follow from frame arithmetic.
    int         m_prev, m_lastdir, m_steps, m_d;
    logic [2:0] m_cur;
    logic [7:0] m_y;
    logic       m_wrap;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input bit en, input bit md, input logic [2:0] s);
        int ns;
        ns = !en ? 0 : (md ? 2 : 1);
        m_wrap = 1'b0;
        if (ns == 1) begin
            m_cur     = s;
            m_lastdir = 1;
        end else if (ns == 2) begin
            if (m_prev == 1 || (m_prev == 0 && m_lastdir != 0)) begin
                m_steps = 0;
            end else if (m_prev == 2) begin
                m_steps++;
                m_wrap = ((m_steps % (8 * (m_d + 1))) == 0);
            end
            m_cur     = 3'((m_steps / (m_d + 1)) % 8);
            m_lastdir = 0;
        end
        m_prev = ns;
        m_y = (ns == 0) ? 8'hFF : ~(8'h01 << m_cur);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; g1 = 1'b1; g2an = 1'b0; g2bn = 1'b0;
        mode = 1'b0; sel = 3'd5; div_load = '0;
        cyc(); cyc();
        n_cmp++; if (y_n !== 8'hFF) begin n_bad++; $display("FAIL reset_y: got %h expected ff", y_n); end
        n_cmp++; if (cur_sel !== 3'd0) begin n_bad++; $display("FAIL reset_cur: got %0d expected 0", cur_sel); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        rst_n = 1'b1;
        cyc();
        n_cmp++; if (y_n !== 8'hDF) begin n_bad++; $display("FAIL reset_release_y: got %h expected df", y_n); end
        n_cmp++; if (cur_sel !== 3'd5) begin n_bad++; $display("FAIL reset_release_cur: got %0d expected 5", cur_sel); end
    endtask

    task automatic test_direct();
        logic [7:0] e;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            cyc();
            e = ~(8'h01 << s);
            n_cmp++; if (y_n !== e) begin n_bad++; $display("FAIL direct_y sel=%0d: got %h expected %h", s, y_n, e); end
            n_cmp++; if (cur_sel !== 3'(s)) begin n_bad++; $display("FAIL direct_cur: got %0d expected %0d", cur_sel, s); end
        end
        g2an = 1'b1;
        cyc();
        n_cmp++; if (y_n !== 8'hFF) begin n_bad++; $display("FAIL direct_disable_y: got %h expected ff", y_n); end
        n_cmp++; if (cur_sel !== 3'd7) begin n_bad++; $display("FAIL direct_disable_cur: got %0d expected 7", cur_sel); end
        g2an = 1'b0;
    endtask

    task automatic test_scan_frame(input int d, input int frames);
        int         wraps, ec, len;
        logic       ew;
        logic [7:0] e;
        wraps = 0;
        len = frames * 8 * (d + 1) + 1;
        mode = 1'b0; cyc();
        mode = 1'b1; div_load = 16'(d);
        for (int j = 0; j < len; j++) begin
            cyc();
            ec = (j / (d + 1)) % 8;
            ew = (j > 0) && ((j % (8 * (d + 1))) == 0);
            e  = ~(8'h01 << ec);
            if (wrap === 1'b1) wraps++;
            n_cmp++; if (cur_sel !== 3'(ec)) begin n_bad++; $display("FAIL scan_cur d=%0d j=%0d: got %0d expected %0d", d, j, cur_sel, ec); end
            n_cmp++; if (y_n !== e) begin n_bad++; $display("FAIL scan_y d=%0d j=%0d: got %h expected %h", d, j, y_n, e); end
            n_cmp++; if (wrap !== ew) begin n_bad++; $display("FAIL scan_wrap d=%0d j=%0d: got %b expected %b", d, j, wrap, ew); end
        end
        n_cmp++; if (wraps != frames) begin n_bad++; $display("FAIL scan_wrap_count d=%0d: got %0d expected %0d", d, wraps, frames); end
    endtask

    task automatic test_freeze();
        mode = 1'b0; cyc();
        mode = 1'b1; div_load = 16'd2;
        cyc();
        repeat (10) cyc();
        n_cmp++; if (cur_sel !== 3'd3) begin n_bad++; $display("FAIL freeze_pre_cur: got %0d expected 3", cur_sel); end
        g1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            n_cmp++; if (y_n !== 8'hFF) begin n_bad++; $display("FAIL freeze_y k=%0d: got %h expected ff", k, y_n); end
            n_cmp++; if (cur_sel !== 3'd3) begin n_bad++; $display("FAIL freeze_cur k=%0d: got %0d expected 3", k, cur_sel); end
        end
        g1 = 1'b1;
        cyc();
        n_cmp++; if (y_n !== 8'hF7) begin n_bad++; $display("FAIL resume_y0: got %h expected f7", y_n); end
        cyc();
        n_cmp++; if (cur_sel !== 3'd3) begin n_bad++; $display("FAIL resume_cur1: got %0d expected 3", cur_sel); end
        cyc();
        n_cmp++; if (y_n !== 8'hEF) begin n_bad++; $display("FAIL resume_y2: got %h expected ef", y_n); end
    endtask

    task automatic test_div_lower();
        mode = 1'b0; cyc();
        mode = 1'b1; div_load = 16'd5;
        cyc();
        repeat (4) cyc();
        n_cmp++; if (cur_sel !== 3'd0) begin n_bad++; $display("FAIL lower_pre_cur: got %0d expected 0", cur_sel); end
        div_load = 16'd1;
        cyc();
        n_cmp++; if (cur_sel !== 3'd1) begin n_bad++; $display("FAIL lower_tick_cur: got %0d expected 1", cur_sel); end
        cyc();
        n_cmp++; if (cur_sel !== 3'd1) begin n_bad++; $display("FAIL lower_dwell_cur: got %0d expected 1", cur_sel); end
        cyc();
        n_cmp++; if (cur_sel !== 3'd2) begin n_bad++; $display("FAIL lower_next_cur: got %0d expected 2", cur_sel); end
    endtask

    task automatic test_active_high();
        rst2_n = 1'b1;
        g1b = 1'b1; g2anb = 1'b0; g2bnb = 1'b0; mode2 = 1'b0; sel2 = 4'd9; div2 = 8'd1;
        cyc();
        n_cmp++; if (y2 !== 16'h0200) begin n_bad++; $display("FAIL ah_direct_y: got %h expected 0200", y2); end
        n_cmp++; if (cur2 !== 4'd9) begin n_bad++; $display("FAIL ah_direct_cur: got %0d expected 9", cur2); end
        mode2 = 1'b1;
        repeat (5) cyc();
        n_cmp++; if (y2 !== 16'h0004) begin n_bad++; $display("FAIL ah_scan_y: got %h expected 0004", y2); end
        #2 rst2_n = 1'b0;
        #1;
        n_cmp++; if (y2 !== 16'h0000) begin n_bad++; $display("FAIL ah_reset_y: got %h expected 0000", y2); end
        n_cmp++; if (cur2 !== 4'd0) begin n_bad++; $display("FAIL ah_reset_cur: got %0d expected 0", cur2); end
        @(negedge clk);
        rst2_n = 1'b1;
        cyc();
        n_cmp++; if (y2 !== 16'h0001) begin n_bad++; $display("FAIL ah_restart_y0: got %h expected 0001", y2); end
        n_cmp++; if (wrap2 !== 1'b0) begin n_bad++; $display("FAIL ah_restart_wrap: got %b expected 0", wrap2); end
        cyc();
        n_cmp++; if (cur2 !== 4'd0) begin n_bad++; $display("FAIL ah_restart_cur1: got %0d expected 0", cur2); end
        cyc();
        n_cmp++; if (y2 !== 16'h0002) begin n_bad++; $display("FAIL ah_restart_y2: got %h expected 0002", y2); end
    endtask

    task automatic test_random();
        int         r, v;
        logic [2:0] s;
        rst_n = 1'b0; g1 = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_prev = 0; m_lastdir = 0; m_steps = 0; m_cur = '0;
        for (int seg = 0; seg < 4; seg++) begin
            m_d = int'($urandom_range(0, 3));
            div_load = 16'(m_d);
            for (int k = 0; k < 160; k++) begin
                r = (k == 0) ? 15 : int'($urandom_range(0, 15));
                s = 3'($urandom_range(0, 7));
                if (r == 14) begin
                    v = int'($urandom_range(0, 6));
                    if (v >= 4) v++;
                    {g1, g2an, g2bn} = 3'(v);
                end else begin
                    {g1, g2an, g2bn} = 3'b100;
                end
                mode = (r != 15);
                sel  = s;
                model_step(g1 & ~g2an & ~g2bn, mode, s);
                cyc();
                n_cmp++; if (y_n !== m_y) begin n_bad++; $display("FAIL rand_y seg=%0d k=%0d: got %h expected %h", seg, k, y_n, m_y); end
                n_cmp++; if (cur_sel !== m_cur) begin n_bad++; $display("FAIL rand_cur seg=%0d k=%0d: got %0d expected %0d", seg, k, cur_sel, m_cur); end
                n_cmp++; if (wrap !== m_wrap) begin n_bad++; $display("FAIL rand_wrap seg=%0d k=%0d: got %b expected %b", seg, k, wrap, m_wrap); end
            end
        end
    endtask

    initial begin
        rst2_n = 1'b0; g1b = 1'b0; g2anb = 1'b0; g2bnb = 1'b0;
        mode2 = 1'b0; sel2 = '0; div2 = '0;
        test_reset();
        test_direct();
        test_scan_frame(2, 2);
        test_scan_frame(0, 2);
        test_freeze();
        test_div_lower();
        test_active_high();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
